// File: rtl/rsa_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rsa_ctrl                                                      |
// | Purpose  : RSA modular exponentiation sequencer C = M^E mod P. Drives a  |
// |            shared Montgomery multiplier through a left-to-right          |
// |            square-and-multiply loop that always walks all WIDTH bits.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rsa_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] r2,
  output logic             mmm_start,
  output logic [WIDTH-1:0] mmm_a,
  output logic [WIDTH-1:0] mmm_b,
  output logic [WIDTH-1:0] mmm_p,
  input  logic             mmm_done,
  input  logic [WIDTH-1:0] mmm_r,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_THREE = WIDTH'(3);
  localparam logic [IDX_W-1:0] C_MSB   = IDX_W'(WIDTH - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHECK = 4'd1,
    S_PRE_M = 4'd2,
    S_PRE_A = 4'd3,
    S_SQR   = 4'd4,
    S_MUL   = 4'd5,
    S_POST  = 4'd6,
    S_DONE  = 4'd7,
    S_ABORT = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  p_q, p_d;
  logic [WIDTH-1:0]  e_q, e_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [WIDTH-1:0]  r2_q, r2_d;
  logic [WIDTH-1:0]  mbar_q, mbar_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [WIDTH-1:0]  c_q, c_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              mmm_start_q, mmm_start_d;
  logic [WIDTH-1:0]  mmm_a_q, mmm_a_d;
  logic [WIDTH-1:0]  mmm_b_q, mmm_b_d;
  logic [WIDTH-1:0]  mmm_p_q, mmm_p_d;

  logic w_ret;        // outstanding multiply completes this cycle
  logic w_bad_ops;    // latched operands unusable for Montgomery
  logic w_advance;    // move to the next exponent bit
  logic w_launch;     // issue a multiply on this edge
  logic w_mul_state;  // state_d is one of the multiply states

  assign w_ret     = pend_q & mmm_done;
  assign w_bad_ops = ~p_q[0] | (p_q < C_THREE) | (m_q >= p_q) | (r2_q >= p_q);

  // Next-state, datapath register and registered-output computation
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    e_d         = e_q;
    m_d         = m_q;
    r2_d        = r2_q;
    mbar_d      = mbar_q;
    a_d         = a_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    c_d         = c_q;
    error_d     = error_q;
    mmm_a_d     = mmm_a_q;
    mmm_b_d     = mmm_b_q;
    mmm_p_d     = mmm_p_q;
    mmm_start_d = 1'b0;
    w_advance   = 1'b0;
    w_launch    = 1'b0;
    w_mul_state = 1'b0;

    // A returning result retires the outstanding multiply in every state,
    // including ABORT where the value is simply dropped.
    if (w_ret) begin
      pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !clear) begin
          p_d     = p;
          e_d     = e;
          m_d     = m;
          r2_d    = r2;
          mmm_p_d = p;
          error_d = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_bad_ops) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d   = C_MSB;
          state_d = S_PRE_M;
        end
      end
      S_PRE_M: begin
        if (w_ret) begin
          mbar_d  = mmm_r;
          state_d = S_PRE_A;
        end
      end
      S_PRE_A: begin
        if (w_ret) begin
          a_d     = mmm_r;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        if (w_ret) begin
          a_d = mmm_r;
          if (e_q[idx_q]) begin
            state_d = S_MUL;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (w_ret) begin
          a_d       = mmm_r;
          w_advance = 1'b1;
        end
      end
      S_POST: begin
        if (w_ret) begin
          c_d     = mmm_r;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        if (!pend_q || mmm_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Leading zeros are still squared so latency depends only on popcount(E)
    if (w_advance) begin
      if (idx_q == '0) begin
        state_d = S_POST;
      end else begin
        idx_d   = idx_q - 1'b1;
        state_d = S_SQR;
      end
    end

    // Clear pre-empts everything; the result and error flag are left as they
    // were, and ABORT is only needed while a multiply is still in flight.
    if (clear && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
      c_d     = c_q;
      error_d = error_q;
      state_d = pend_d ? S_ABORT : S_IDLE;
    end

    w_mul_state = (state_d == S_PRE_M) || (state_d == S_PRE_A) ||
                  (state_d == S_SQR)   || (state_d == S_MUL)   ||
                  (state_d == S_POST);
    w_launch    = w_mul_state && ((state_q == S_CHECK) || w_ret);

    // Operands come from the freshly computed A / Mbar so a multiply can be
    // issued on the same edge that the previous result is captured.
    if (w_launch) begin
      mmm_start_d = 1'b1;
      pend_d      = 1'b1;
      case (state_d)
        S_PRE_M: begin mmm_a_d = m_q;   mmm_b_d = r2_q;   end
        S_PRE_A: begin mmm_a_d = C_ONE; mmm_b_d = r2_q;   end
        S_SQR:   begin mmm_a_d = a_d;   mmm_b_d = a_d;    end
        S_MUL:   begin mmm_a_d = a_d;   mmm_b_d = mbar_d; end
        default: begin mmm_a_d = a_d;   mmm_b_d = C_ONE;  end
      endcase
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      e_q         <= '0;
      m_q         <= '0;
      r2_q        <= '0;
      mbar_q      <= '0;
      a_q         <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      c_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mmm_start_q <= 1'b0;
      mmm_a_q     <= '0;
      mmm_b_q     <= '0;
      mmm_p_q     <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      e_q         <= e_d;
      m_q         <= m_d;
      r2_q        <= r2_d;
      mbar_q      <= mbar_d;
      a_q         <= a_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      c_q         <= c_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      mmm_start_q <= mmm_start_d;
      mmm_a_q     <= mmm_a_d;
      mmm_b_q     <= mmm_b_d;
      mmm_p_q     <= mmm_p_d;
    end
  end

  assign mmm_start = mmm_start_q;
  assign mmm_a     = mmm_a_q;
  assign mmm_b     = mmm_b_q;
  assign mmm_p     = mmm_p_q;
  assign c         = c_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
`default_nettype wire
